// File: rtl/hazard_unit_if.sv
// Hazard controller bundle: pipeline status in, stall/flush/extend control out.
// The pipeline side is the master; hazard_unit is the slave.
interface hazard_unit_if;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic       ex_valid;
  logic       mem_valid;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       ex_md_start;
  logic       ex_md_is_div;
  logic       ex_branch_taken;
  logic       mem_req;
  logic       mem_ready;
  logic       exc_req;
  logic       stall_clr;

  logic [4:0]  stall;
  logic [4:0]  flush;
  logic [4:0]  extend;
  logic [1:0]  pc_redirect;
  logic        md_busy;
  logic        md_done;
  logic        bus_err;
  logic [15:0] stall_count;
  logic        dbg_state;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, mem_valid, ex_is_load,
           ex_rd, ex_md_start, ex_md_is_div, ex_branch_taken, mem_req, mem_ready,
           exc_req, stall_clr,
    input  stall, flush, extend, pc_redirect, md_busy, md_done, bus_err,
           stall_count, dbg_state
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_valid, mem_valid, ex_is_load,
           ex_rd, ex_md_start, ex_md_is_div, ex_branch_taken, mem_req, mem_ready,
           exc_req, stall_clr,
    output stall, flush, extend, pc_redirect, md_busy, md_done, bus_err,
           stall_count, dbg_state
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use stall, mult/div EX occupancy, MEM wait
// with timeout, and branch/exception flush with exception taking precedence.
module hazard_unit #(
  parameter int MUL_CYCLES  = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_unit_if.slave hif
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_MD_BUSY = 1'b1} state_t;

  state_t            r_state;
  logic [5:0]        r_md_cnt;
  logic [WAIT_W-1:0] r_mem_wait_cnt;
  logic [15:0]       r_stall_count;

  logic       w_mem_wait;
  logic       w_timeout;
  logic       w_exc_take;
  logic       w_md_start;
  logic       w_md_last;
  logic       w_branch;
  logic       w_rs_hit;
  logic       w_rt_hit;
  logic       w_load_use;
  logic [4:0] w_stall;
  logic [4:0] w_flush;
  logic [4:0] w_extend;
  logic [1:0] w_redirect;
  logic       w_md_done;
  logic       w_any_hold;

  assign w_mem_wait = hif.mem_valid & hif.mem_req & ~hif.mem_ready;
  assign w_timeout  = w_mem_wait & (r_mem_wait_cnt == WAIT_W'(MEM_TIMEOUT));
  assign w_exc_take = hif.mem_valid & (hif.exc_req | w_timeout);
  assign w_md_start = (r_state == S_IDLE) & hif.ex_valid & hif.ex_md_start;
  assign w_md_last  = (r_state == S_MD_BUSY) & (r_md_cnt == 6'd1);

  // Exception is excluded here, so !extend[1] reduces to "MEM not waiting".
  assign w_branch = hif.ex_valid & hif.ex_branch_taken & ~w_mem_wait & ~w_exc_take &
                    (r_state == S_IDLE);

  assign w_rs_hit   = hif.id_uses_rs & (hif.id_rs == hif.ex_rd);
  assign w_rt_hit   = hif.id_uses_rt & (hif.id_rt == hif.ex_rd);
  assign w_load_use = hif.ex_valid & hif.ex_is_load & (hif.ex_rd != 5'd0) &
                      (w_rs_hit | w_rt_hit) & ~w_branch & ~w_exc_take;

  always_comb begin
    w_stall    = '0;
    w_flush    = '0;
    w_extend   = '0;
    w_redirect = 2'b00;
    w_md_done  = 1'b0;
    if (w_exc_take) begin
      w_flush[1] = 1'b1;
      w_redirect = 2'b10;
    end else begin
      w_extend[1] = w_mem_wait;
      w_extend[2] = w_md_start | ((r_state == S_MD_BUSY) & ~w_md_last);
      w_md_done   = w_md_last;
      if (w_branch) begin
        w_flush[3] = 1'b1;
        w_redirect = 2'b01;
      end
      w_stall[3] = w_load_use;
    end
  end

  assign w_any_hold = |(w_stall | w_extend);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_IDLE;
      r_md_cnt       <= '0;
      r_mem_wait_cnt <= '0;
    end else if (w_exc_take) begin
      r_state        <= S_IDLE;
      r_md_cnt       <= '0;
      r_mem_wait_cnt <= '0;
    end else begin
      r_mem_wait_cnt <= w_mem_wait ? r_mem_wait_cnt + 1'b1 : '0;
      case (r_state)
        S_IDLE: begin
          if (w_md_start) begin
            r_md_cnt <= hif.ex_md_is_div ? 6'(DIV_CYCLES - 1) : 6'(MUL_CYCLES - 1);
            r_state  <= S_MD_BUSY;
          end
        end
        S_MD_BUSY: begin
          r_md_cnt <= r_md_cnt - 6'd1;
          if (w_md_last) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_count <= '0;
    end else if (hif.stall_clr) begin
      r_stall_count <= '0;
    end else if (w_any_hold && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  // Reset forces every output low even though most are combinational from inputs.
  assign hif.stall       = rst ? w_stall : 5'd0;
  assign hif.flush       = rst ? w_flush : 5'd0;
  assign hif.extend      = rst ? w_extend : 5'd0;
  assign hif.pc_redirect = rst ? w_redirect : 2'b00;
  assign hif.md_busy     = rst & (r_state == S_MD_BUSY);
  assign hif.md_done     = rst & w_md_done;
  assign hif.bus_err     = rst & w_timeout;
  assign hif.stall_count = r_stall_count;
  assign hif.dbg_state   = rst & (r_state == S_MD_BUSY);
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: load-use, mult/div sequencing, MEM wait and
// timeout, branch hold-off, exception during divide, and reset mid-operation.
module tb_hazard_unit;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  hazard_unit_if hif();

  hazard_unit #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (32),
    .MEM_TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hif(hif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [4:0] st, input logic [4:0] fl,
                         input logic [4:0] ex, input logic [1:0] pc);
    check_eq({tag, ".stall"},  32'(hif.stall),       32'(st));
    check_eq({tag, ".flush"},  32'(hif.flush),       32'(fl));
    check_eq({tag, ".extend"}, 32'(hif.extend),      32'(ex));
    check_eq({tag, ".pc"},     32'(hif.pc_redirect), 32'(pc));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.id_uses_rs = 1'b0; hif.id_uses_rt = 1'b0;
    hif.ex_valid = 1'b0; hif.mem_valid = 1'b0; hif.ex_is_load = 1'b0; hif.ex_rd = 5'd0;
    hif.ex_md_start = 1'b0; hif.ex_md_is_div = 1'b0; hif.ex_branch_taken = 1'b0;
    hif.mem_req = 1'b0; hif.mem_ready = 1'b0; hif.exc_req = 1'b0; hif.stall_clr = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs, input logic urs,
                              input logic [4:0] rt, input logic urt);
    hif.ex_valid = 1'b1; hif.ex_is_load = 1'b1; hif.ex_rd = rd;
    hif.id_rs = rs; hif.id_uses_rs = urs; hif.id_rt = rt; hif.id_uses_rt = urt;
  endtask

  task automatic set_mem_wait();
    hif.mem_valid = 1'b1; hif.mem_req = 1'b1; hif.mem_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_vec(tag, 5'd0, 5'd0, 5'd0, 2'd0);
    check_eq({tag, ".md_busy"}, 32'(hif.md_busy), 32'd0);
    check_eq({tag, ".md_done"}, 32'(hif.md_done), 32'd0);
    check_eq({tag, ".bus_err"}, 32'(hif.bus_err), 32'd0);
    check_eq({tag, ".cnt"},     32'(hif.stall_count), 32'd0);
    check_eq({tag, ".dbg"},     32'(hif.dbg_state), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    // Hazard-causing inputs must not leak through while reset is held.
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    set_mem_wait();
    hif.exc_req = 1'b1;
    #1;
    check_all_zero("reset");
    idle_inputs();
    #20 rst = 1'b1;
    tick();

    // Load-use
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1 chk_vec("lu_rs", 5'b01000, 5'd0, 5'd0, 2'd0);
    tick();
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
    #1 chk_vec("lu_rd0", 5'd0, 5'd0, 5'd0, 2'd0);
    tick();
    set_load_use(5'd7, 5'd3, 1'b0, 5'd7, 1'b0);
    #1 chk_vec("lu_nouse", 5'd0, 5'd0, 5'd0, 2'd0);
    tick();
    set_load_use(5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
    #1 chk_vec("lu_rt", 5'b01000, 5'd0, 5'd0, 2'd0);
    tick();
    hif.ex_is_load = 1'b0;
    #1 chk_vec("lu_noload", 5'd0, 5'd0, 5'd0, 2'd0);
    check_eq("cnt_after_lu", 32'(hif.stall_count), 32'd2);
    tick();
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    hif.ex_valid = 1'b0;
    #1 chk_vec("lu_exinv", 5'd0, 5'd0, 5'd0, 2'd0);
    tick();
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    hif.stall_clr = 1'b1;
    #1 chk_vec("lu_clr", 5'b01000, 5'd0, 5'd0, 2'd0);
    tick();
    idle_inputs();
    #1 check_eq("cnt_cleared", 32'(hif.stall_count), 32'd0);
    tick();

    // Multiply, with a spurious start held in the first busy cycle
    hif.ex_valid = 1'b1; hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b0;
    #1 chk_vec("mul_t0", 5'd0, 5'd0, 5'b00100, 2'd0);
    check_eq("mul_t0.busy", 32'(hif.md_busy), 32'd0);
    check_eq("mul_t0.done", 32'(hif.md_done), 32'd0);
    tick();
    #1 chk_vec("mul_t1", 5'd0, 5'd0, 5'b00100, 2'd0);
    check_eq("mul_t1.busy", 32'(hif.md_busy), 32'd1);
    tick();
    hif.ex_md_start = 1'b0;
    #1 chk_vec("mul_t2", 5'd0, 5'd0, 5'b00100, 2'd0);
    check_eq("mul_t2.busy", 32'(hif.md_busy), 32'd1);
    check_eq("mul_t2.done", 32'(hif.md_done), 32'd0);
    tick();
    #1 chk_vec("mul_t3", 5'd0, 5'd0, 5'd0, 2'd0);
    check_eq("mul_t3.busy", 32'(hif.md_busy), 32'd1);
    check_eq("mul_t3.done", 32'(hif.md_done), 32'd1);
    tick();
    idle_inputs();
    #1 check_eq("mul_t4.busy", 32'(hif.md_busy), 32'd0);
    check_eq("mul_t4.done", 32'(hif.md_done), 32'd0);
    check_eq("cnt_after_mul", 32'(hif.stall_count), 32'd3);
    tick();

    // Short MEM wait
    for (int i = 1; i <= 3; i++) begin
      set_mem_wait();
      #1 chk_vec($sformatf("wait3_%0d", i), 5'd0, 5'd0, 5'b00010, 2'd0);
      check_eq($sformatf("wait3_%0d.berr", i), 32'(hif.bus_err), 32'd0);
      tick();
    end
    hif.mem_ready = 1'b1;
    #1 chk_vec("wait3_rdy", 5'd0, 5'd0, 5'd0, 2'd0);
    tick();
    idle_inputs();
    tick();

    // Timeout on the 17th wait cycle
    set_mem_wait();
    for (int i = 1; i <= 16; i++) begin
      #1 check_eq($sformatf("wait_%0d.ext", i), 32'(hif.extend), 32'b00010);
      check_eq($sformatf("wait_%0d.berr", i), 32'(hif.bus_err), 32'd0);
      tick();
    end
    #1 chk_vec("timeout", 5'd0, 5'b00010, 5'd0, 2'b10);
    check_eq("timeout.berr", 32'(hif.bus_err), 32'd1);
    tick();
    #1 chk_vec("post_to", 5'd0, 5'd0, 5'b00010, 2'd0);
    check_eq("post_to.berr", 32'(hif.bus_err), 32'd0);
    tick();
    idle_inputs();
    tick();

    // Branch held off by MEM wait
    set_mem_wait();
    hif.ex_valid = 1'b1; hif.ex_branch_taken = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      #1 chk_vec($sformatf("br_hold_%0d", i), 5'd0, 5'd0, 5'b00010, 2'd0);
      tick();
    end
    hif.mem_ready = 1'b1;
    #1 chk_vec("br_go", 5'd0, 5'b01000, 5'd0, 2'b01);
    tick();
    idle_inputs();
    set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    hif.ex_branch_taken = 1'b1;
    #1 chk_vec("br_over_lu", 5'd0, 5'b01000, 5'd0, 2'b01);
    tick();
    idle_inputs();
    set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    hif.mem_valid = 1'b1; hif.exc_req = 1'b1;
    #1 chk_vec("exc_over_lu", 5'd0, 5'b00010, 5'd0, 2'b10);
    tick();
    idle_inputs();
    tick();

    // Exception during a divide
    hif.ex_valid = 1'b1; hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b1;
    #1 chk_vec("div_t0", 5'd0, 5'd0, 5'b00100, 2'd0);
    tick();
    hif.ex_md_start = 1'b0;
    tick();
    hif.mem_valid = 1'b1; hif.exc_req = 1'b1;
    #1 chk_vec("div_exc", 5'd0, 5'b00010, 5'd0, 2'b10);
    check_eq("div_exc.busy", 32'(hif.md_busy), 32'd1);
    check_eq("div_exc.done", 32'(hif.md_done), 32'd0);
    tick();
    idle_inputs();
    #1 check_eq("div_after.busy", 32'(hif.md_busy), 32'd0);
    check_eq("div_after.ext", 32'(hif.extend), 32'd0);
    check_eq("div_after.done", 32'(hif.md_done), 32'd0);
    tick();

    // Reset in the middle of a divide
    hif.ex_valid = 1'b1; hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b1;
    tick();
    hif.ex_md_start = 1'b0;
    tick();
    #2 rst = 1'b0;
    set_load_use(5'd6, 5'd6, 1'b1, 5'd0, 1'b0);
    set_mem_wait();
    #1 check_all_zero("rst_mid");
    idle_inputs();
    #3 rst = 1'b1;
    tick();
    #1 check_all_zero("rst_rel");
    tick();
    hif.ex_valid = 1'b1; hif.ex_md_start = 1'b1; hif.ex_md_is_div = 1'b0;
    #1 check_eq("mul2_t0.ext", 32'(hif.extend), 32'b00100);
    tick();
    hif.ex_md_start = 1'b0;
    #1 check_eq("mul2_t1.ext", 32'(hif.extend), 32'b00100);
    tick();
    #1 check_eq("mul2_t2.ext", 32'(hif.extend), 32'b00100);
    tick();
    #1 check_eq("mul2_t3.ext", 32'(hif.extend), 32'd0);
    check_eq("mul2_t3.done", 32'(hif.md_done), 32'd1);
    tick();
    idle_inputs();
    #1 check_eq("mul2_t4.busy", 32'(hif.md_busy), 32'd0);
    check_eq("mul2.cnt", 32'(hif.stall_count), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage core. Each cycle it sources the `stall`, `flush` and `extend` vectors that drive `pipe_unit`. It detects load-use hazards, sequences multi-cycle mult/div occupancy of EX, tracks data-memory wait states with a timeout, and issues branch/exception flushes with fixed priority. Stage bit order: 4 = IF, 3 = ID, 2 = EX, 1 = MEM, 0 = WB. A bit set at stage k affects stage k and every younger stage.

## Interface
- `MUL_CYCLES`, default 4: EX residence of a multiply, in cycles. Must be ≥2.
- `DIV_CYCLES`, default 32: EX residence of a divide, in cycles. Must be ≥2.
- `MEM_TIMEOUT`, default 16: consecutive MEM wait cycles before a bus error.
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `id_rs`, `id_rt` input 5 each: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` input 1 each: ID actually reads rs/rt.
- `ex_valid`, `mem_valid` input 1 each: stage holds a real instruction (not a bubble).
- `ex_is_load` input 1: EX instruction is a load.
- `ex_rd` input 5: destination register of the EX instruction.
- `ex_md_start` input 1: EX holds a mult/div entering EX this cycle.
- `ex_md_is_div` input 1: qualifies `ex_md_start`; 1 = divide.
- `ex_branch_taken` input 1: a taken branch or jump is resolved in EX.
- `mem_req`, `mem_ready` input 1 each: MEM data-memory request and ready.
- `exc_req` input 1: the MEM instruction raises an exception.
- `stall_clr` input 1: synchronous clear of `stall_count`.
- `stall`, `flush`, `extend` output 5 each: control vectors to `pipe_unit`.
- `pc_redirect` output 2: 00 none, 01 branch target, 10 exception vector.
- `md_busy` output 1: mult/div sequencer is not idle.
- `md_done` output 1: one-cycle pulse when a mult/div completes.
- `bus_err` output 1: one-cycle pulse when the memory wait times out.
- `stall_count` output 16: saturating count of cycles with `stall|extend` nonzero.

## Operation
- State machine: IDLE, MD_BUSY. A 6-bit down-counter `md_cnt` runs alongside. A separate counter `mem_wait_cnt` is sized ≥ clog2(MEM_TIMEOUT+1).
- Outputs are combinational from state and inputs; the control vectors are valid in the same cycle.
- **Exception** (priority 1): `exc_take = mem_valid & (exc_req | timeout)`.
  - Asserts `flush[1]` and `pc_redirect=10`. All other stall/flush/extend bits are 0.
  - The FSM goes to IDLE, and `md_cnt` and `mem_wait_cnt` are cleared.
- **MEM wait** (priority 2): `mem_valid & mem_req & !mem_ready` asserts `extend[1]`.
  - `mem_wait_cnt` increments each such cycle and clears otherwise.
  - `timeout` = wait condition true while `mem_wait_cnt == MEM_TIMEOUT`. In that cycle `bus_err=1` and the exception path applies.
- **Mult/div**:
  - In IDLE, `ex_valid & ex_md_start` loads `md_cnt` with N−1, where N = `ex_md_is_div` ? DIV_CYCLES : MUL_CYCLES. The FSM goes to MD_BUSY and `extend[2]=1` that cycle.
  - In MD_BUSY, `md_cnt` decrements each cycle.
    - If `md_cnt != 1`: `extend[2]=1`.
    - If `md_cnt == 1`: `extend[2]=0`, `md_done=1`, and the FSM goes to IDLE.
  - `extend[2]` is therefore high N−1 cycles, and the instruction occupies EX for N cycles.
  - The counter runs even while MEM is extended.
  - `md_busy` = (state == MD_BUSY).
- **Branch**: `ex_valid & ex_branch_taken & !extend[1] & !exc_take & state==IDLE` asserts `flush[3]` and `pc_redirect=01`.
  - When held off, the branch remains in EX and is re-evaluated next cycle.
- **Load-use**:
  - Condition: `ex_valid & ex_is_load & ex_rd!=0` and a match on rs or rt, each gated by its use bit.
  - Response: `stall[3]`, i.e. ID and IF hold and a bubble enters EX.
  - Suppressed when `flush[3]` or `exc_take` is active.
- `stall_count` increments when `stall|extend != 0`, and saturates at 16'hFFFF.
  - `stall_clr` has priority over the increment and sets the count to 0.

## Timing
- Reset (`rst` low, asynchronous):
  - State = IDLE; `md_cnt`, `mem_wait_cnt` and `stall_count` = 0.
  - All outputs are 0 (`stall`, `flush`, `extend`, `pc_redirect`, `md_busy`, `md_done`, `bus_err`, `stall_count`) regardless of the other inputs.
- Reset mid mult/div or mid wait aborts silently. No `md_done` or `bus_err` is issued.
- Hazard detection has zero latency (same cycle). Internal state has one-cycle latency.
- Simultaneous events:
  - Exception wins over everything.
  - MEM extend coexists with `extend[2]` and with `stall[3]`; `pipe_unit` resolves the oldest stage.
  - `ex_md_start` while in MD_BUSY is ignored, because EX is still occupied.
- `md_done` never coincides with `extend[2]`.

## Test plan
- Load `$5` in EX, ID reads rs=`$5` → `stall=00001000` for 1 cycle. The same case with `ex_rd=0` → `stall=0`.
- MUL_CYCLES=4 multiply started at cycle t → `extend[2]` high at t..t+2, `md_done` at t+3, `md_busy` high at t+1..t+3.
- `mem_req` with `mem_ready` low for 3 cycles → `extend[1]` high for 3 cycles, no `bus_err`. Holding ready low for 17 cycles → `bus_err` and `flush[1]` on wait cycle 17, `pc_redirect=10`.
- Taken branch in EX while MEM is waiting → `flush[3]` delayed until the cycle `mem_ready` rises, then `pc_redirect=01`.
- `exc_req` during a divide in MD_BUSY → `flush[1]`, FSM to IDLE, no `md_done`, `md_busy=0` next cycle.
- `rst` asserted mid-divide, then released → all outputs 0, `stall_count=0`. A subsequent multiply sequences normally.
